// File: rtl/bin2bcd_x3_if.sv
// Request/result bundle between a binary source and the three-digit BCD converter.
// The master drives start/bin; the converter (slave) returns bcd/ovf/busy/done.
interface bin2bcd_x3_if;
    logic        start;
    logic [9:0]  bin;
    logic [11:0] bcd;
    logic        ovf;
    logic        busy;
    logic        done;

    modport master (output start, output bin, input bcd, input ovf, input busy, input done);
    modport slave  (input start, input bin, output bcd, output ovf, output busy, output done);
endinterface

// File: rtl/bin2bcd_x3.sv
// Sequential 10-bit binary to 3-digit packed BCD converter (double-dabble, one shift per clock).
// Operands above 999 saturate to 999 and raise ovf; bcd/ovf only move on the completion edge.
module bin2bcd_x3 (
    input  logic          clk,
    input  logic          rst,
    bin2bcd_x3_if.slave   bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state_q, state_d;
    logic [21:0] scratch_q, scratch_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sat_q, sat_d;
    logic [11:0] bcd_q, bcd_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;
    logic [21:0] corrected;
    logic [21:0] shifted;

    function automatic logic [3:0] fix(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Correction stays inside each nibble (max 12), so no inter-digit carry before the shift.
    always_comb begin
        corrected = {fix(scratch_q[21:18]), fix(scratch_q[17:14]), fix(scratch_q[13:10]),
                     scratch_q[9:0]};
        shifted   = {corrected[20:0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            scratch_q <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    scratch_d = {12'b0, bus.bin};
                    sat_d     = (bus.bin > 10'd999);
                    cnt_d     = 4'd0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted;
                cnt_d     = cnt_q + 4'd1;
                // Out-of-range operands still take all 10 shifts to keep latency fixed.
                if (cnt_q == 4'd9) begin
                    bcd_d   = sat_q ? 12'h999 : shifted[21:10];
                    ovf_d   = sat_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.bcd  = bcd_q;
    assign bus.ovf  = ovf_q;
    assign bus.done = done_q;
    assign bus.busy = (state_q == SHIFT);
endmodule

// File: tb/tb_bin2bcd_x3.sv
// Directed plus randomized/exhaustive bench for bin2bcd_x3 against a decimal-arithmetic model.
module tb_bin2bcd_x3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [11:0] last_bcd = 12'h000;
    logic        last_ovf = 1'b0;

    bin2bcd_x3_if bif();
    bin2bcd_x3 dut (.clk(clk), .rst(rst), .bus(bif));

    always #5 clk = ~clk;

    function automatic logic [11:0] ref_bcd(input int v);
        int d;
        d = (v > 999) ? 999 : v;
        return {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a conversion in the current cycle and ends just after the completion edge.
    // pulse_at>0 re-asserts start with pv during SHIFT to confirm it is ignored.
    task automatic do_conv(input int v, input int pulse_at, input int pv);
        logic [11:0] exp;
        logic        exp_ovf;
        exp     = ref_bcd(v);
        exp_ovf = (v > 999);
        bif.start = 1'b1;
        bif.bin   = 10'(v);
        tick();
        for (int i = 1; i <= 10; i++) begin
            chk("busy_shift", bif.busy, 1);
            chk("done_low", bif.done, 0);
            chk("bcd_hold", bif.bcd, last_bcd);
            chk("ovf_hold", bif.ovf, last_ovf);
            bif.start = (i == pulse_at);
            bif.bin   = (i == pulse_at) ? 10'(pv) : 10'($urandom_range(0, 1023));
            tick();
        end
        bif.start = 1'b0;
        chk("done_pulse", bif.done, 1);
        chk("busy_end", bif.busy, 0);
        chk("bcd_result", bif.bcd, exp);
        chk("ovf_result", bif.ovf, exp_ovf);
        chk("digit_h", bif.bcd[11:8] <= 4'd9, 1);
        chk("digit_t", bif.bcd[7:4] <= 4'd9, 1);
        chk("digit_u", bif.bcd[3:0] <= 4'd9, 1);
        last_bcd = exp;
        last_ovf = exp_ovf;
    endtask

    task automatic idle_check(input string tag);
        tick();
        chk({tag, "_done"}, bif.done, 0);
        chk({tag, "_busy"}, bif.busy, 0);
        chk({tag, "_bcd"}, bif.bcd, last_bcd);
    endtask

    initial begin
        bif.start = 1'b0;
        bif.bin   = '0;
        #2;
        chk("rst_bcd", bif.bcd, 0);
        chk("rst_ovf", bif.ovf, 0);
        chk("rst_busy", bif.busy, 0);
        chk("rst_done", bif.done, 0);
        tick();
        tick();
        rst = 1'b0;

        do_conv(0, 0, 0);
        idle_check("after0");
        do_conv(255, 0, 0);
        idle_check("after255");
        do_conv(999, 0, 0);
        do_conv(1023, 0, 0);
        do_conv(7, 0, 0);
        idle_check("after7");

        // start during SHIFT is dropped; start in the done cycle is taken
        do_conv(123, 4, 456);
        do_conv(456, 0, 0);
        idle_check("after456");

        // asynchronous abort mid-conversion
        bif.start = 1'b1;
        bif.bin   = 10'd500;
        tick();
        bif.start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("abort_bcd", bif.bcd, 0);
        chk("abort_ovf", bif.ovf, 0);
        chk("abort_busy", bif.busy, 0);
        chk("abort_done", bif.done, 0);
        last_bcd = 12'h000;
        last_ovf = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        repeat (12) idle_check("post_abort");
        do_conv(42, 0, 0);
        idle_check("after42");

        for (int n = 0; n < 40; n++) begin
            do_conv(int'($urandom_range(0, 1023)), 0, 0);
            if ($urandom_range(0, 1) == 1) idle_check("rand_gap");
        end

        for (int v = 0; v < 1024; v++) do_conv(v, 0, 0);
        idle_check("sweep_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bin2bcd_x3.md
# bin2bcd_x3

Sequential binary-to-BCD converter that sits directly upstream of the three-digit seven-segment display driver. It turns a 10-bit unsigned binary value (0–999) into three packed BCD digits using the shift-and-add-3 (double-dabble) algorithm, one shift per clock. The 12-bit BCD result is held stable on its output so the display shows decimal instead of hex. Inputs above 999 saturate to 999 and set an overflow flag.

## Interface
- No parameters. Input width is fixed at 10 bits and output width at 3 BCD digits.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  conversion request, sampled on the rising edge while idle.
- bin  input  10  unsigned binary operand, captured on the edge that accepts start.
- bcd  output  12  result: [11:8] hundreds, [7:4] tens, [3:0] units. Connects straight to the display driver's 12-bit value input.
- ovf  output  1  set when the last accepted operand exceeded 999; updates together with bcd.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse marking that bcd/ovf were just updated.

## Operation
- States:
  - IDLE: start=1 → load scratch = {12'b0, bin}, sat = (bin > 999), cnt = 0, go to SHIFT. start=0 → stay.
  - SHIFT: runs for exactly 10 edges.
- Each SHIFT edge:
  - Correct each of the three BCD nibbles of scratch[21:10]: a nibble ≥5 gets +3.
  - Shift the whole 22-bit scratch left by 1, filling with 0.
  - cnt <= cnt + 1.
- On the SHIFT edge with cnt==9:
  - bcd <= 12'h999 if sat, otherwise bits [21:10] of the corrected-and-shifted scratch.
  - ovf <= sat; done <= 1; next state IDLE.
- Width rules:
  - Nibble correction is 4-bit; it never exceeds 12, so there is no carry between nibbles before the shift.
  - cnt is 4 bits.
  - Operands 1000–1023 still run all 10 shifts, so latency is constant; the result is replaced by the saturated value.
- bcd and ovf change only on the completion edge. The display never sees an intermediate value.
- start while busy (SHIFT) is ignored and not queued. bin changes during SHIFT have no effect.
- start high in the cycle where done is high (state IDLE) is accepted, so back-to-back conversions are supported.
- start held high continuously gives one conversion every 11 cycles.
- busy = (state == SHIFT), registered.
- done is high only in the cycle after the completion edge and is low in all other cycles.

## Timing
- Reset (asynchronous, active-high): state=IDLE, bcd=12'h000, ovf=0, busy=0, done=0, scratch=0, cnt=0. Outputs go to these values immediately when rst asserts, independent of clk.
- Reset mid-conversion aborts it. bcd returns to 000 and no done pulse is produced.
- First edge after rst deasserts may accept start.
- Latency: start accepted at edge k → busy=1 after edge k. On edge k+10: bcd/ovf valid, done=1, busy=0. After edge k+11: done=0.
- Throughput: one conversion per 11 cycles.
- Outputs are registered; there is no combinational path from start/bin to any output.

## Test plan
- Reset, then start with bin=0 → busy high for 10 cycles; done at edge k+10; bcd=12'h000, ovf=0.
- bin=255 → bcd=12'h255 exactly at edge k+10, with a single-cycle done.
- bin=999 → bcd=12'h999, ovf=0. bin=1023 → bcd=12'h999, ovf=1. Follow with bin=7 → bcd=12'h007, ovf=0.
- Start bin=123, then pulse start with bin=456 at cycle k+4 → ignored; result 12'h123. A start with bin=456 in the done cycle → accepted; 12'h456 at 11 cycles later.
- Start bin=500, assert rst at cycle k+5 → bcd=000, busy=0, no done. After release, bin=42 → 12'h042.
- Exhaustive sweep bin=0..1023 with back-to-back starts:
  - Every result matches the reference decimal digits, saturated above 999.
  - Every digit is ≤9.
  - bcd never changes outside done cycles.
